alu_issue_queue: RTL
====================

Name: alu_issue_queue

Overview:
- Upstream feeder for the 8-bit ALU: buffers 18-bit instructions {op[1:0], A[7:0], B[7:0]} from a producer and presents them one at a time on the ALU instruction bus.
- Holds each instruction stable for its op-dependent latency and drives the multiplier start/check line.
- Flags the cycle in which the ALU output Y/Cout/overflow is valid for the issued instruction.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- ALU_CYCLES, 1, hold cycles for add/and/xor (op 00/01/10).
- MULT_CYCLES, 9, hold cycles for multiply (op 11); ≥2.
- CNT_W, 4, width of the hold counter; must hold MULT_CYCLES-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_instr  in  18  instruction word {op, A, B}.
- in_valid  in  1  producer has a word.
- in_ready  out  1  queue accepts a word this cycle.
- flush  in  1  synchronous: empty the queue; the in-flight op completes.
- alu_instr  out  18  instruction to ALU, registered.
- alu_check  out  1  multiplier start, one-cycle pulse.
- busy  out  1  an op is being held (state != IDLE).
- res_valid  out  1  one-cycle pulse: ALU outputs valid for res_op.
- res_op  out  2  opcode of the completed op.
- fifo_count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, reset_n=0): queue empty, fifo_count=0, state IDLE, alu_instr=0, alu_check=0, res_valid=0, res_op=0, busy=0. Deassertion is synchronised by the caller.
- Reset asserted mid-multiply aborts the op: no res_valid, and alu_instr returns to 0 immediately.
- Push:
  - in_ready = (fifo_count < DEPTH), from registered count only. No same-cycle pop credit when full.
  - Push occurs on a rising edge with in_valid & in_ready.
- Pop: only when fifo_count > 0 at the edge. No empty bypass, so a word pushed into an empty queue issues no earlier than the next edge.
- FSM states:
  - IDLE: if not empty, pop head → alu_instr; load hold counter with (op==2'b11 ? MULT_CYCLES : ALU_CYCLES) - 1; go to HOLD; busy=1.
  - HOLD: alu_instr constant. alu_check=1 only in the first HOLD cycle, and only when op==11. Counter decrements each cycle; at 0 go to DONE.
  - DONE: alu_instr still held. res_valid=1 and res_op=alu_instr[17:16] for exactly this cycle. If the queue is non-empty, pop directly into HOLD (back-to-back); otherwise go to IDLE.
- Throughput:
  - Non-multiply ops: one every ALU_CYCLES+1 cycles.
  - Multiply: one every MULT_CYCLES+1 cycles.
- alu_instr changes only on a pop, or on reset to 0. It is never changed while in HOLD.
- Simultaneous push and pop: both take effect; count unchanged.
- Push and pop when full: only the pop occurs, since in_ready=0.
- flush:
  - Sets count=0 and discards all queued words, including one pushed in the same cycle.
  - Suppresses a pop in the same cycle.
  - Does not disturb the HOLD/DONE op or its res_valid.
- Pointers wrap modulo DEPTH. fifo_count saturates by construction and never exceeds DEPTH.

Decomposition:
- Shared include alu_defs.vh:
  - Opcode constants OP_ADD=2'b00, OP_AND=2'b01, OP_XOR=2'b10, OP_MUL=2'b11.
  - Instruction field positions: OP 17:16, A 15:8, B 7:0.
  - FSM state encodings IDLE/HOLD/DONE.
- One sub-module: instr_fifo (DEPTH×18 register array, push/pop/flush, count, full/empty). The issue FSM lives in the top.

Test Plan:
- Reset then single add 18'h00305 (A=03, B=05):
  - alu_instr=18'h00305 one edge after push, held 1 HOLD cycle.
  - res_valid pulse with res_op=00 on the next cycle; alu_check stays 0.
- Multiply 18'h30F0A with defaults:
  - alu_check high exactly 1 cycle.
  - alu_instr stable for 9 HOLD cycles plus DONE.
  - res_valid on the 10th cycle after issue, res_op=11.
- Push 5 words back-to-back with DEPTH=4 while the ALU is busy on a multiply:
  - in_ready drops after fifo_count=4; the 5th word is stalled until the first pop.
  - Ops issue in push order with back-to-back DONE→HOLD.
- Empty queue with simultaneous push and DONE:
  - Word issues from IDLE on the following edge.
  - No res_valid duplicated, no word lost.
- flush during a multiply with 3 words queued:
  - fifo_count→0 next cycle.
  - The multiply's res_valid still fires; afterwards the FSM goes IDLE, busy=0.
- reset_n pulsed low for 1 ns mid-multiply:
  - All outputs 0 immediately, asynchronously.
  - No res_valid after release; queue empty.

Source files
------------

// File: rtl/alu_issue_queue_pkg.sv
// Shared definitions for the ALU issue queue: instruction layout, opcodes and
// issue FSM state encodings.
package alu_issue_queue_pkg;

    // Instruction word is {op[1:0], A[7:0], B[7:0]}.
    localparam int INSTR_W = 18;
    localparam int OP_HI   = 17;
    localparam int OP_LO   = 16;

    typedef logic [1:0] op_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_DONE = 2'b10
    } issue_state_e;

    // Opcode field of an instruction word.
    function automatic op_t instr_op(input logic [INSTR_W-1:0] instr);
        return instr[OP_HI:OP_LO];
    endfunction

    // True when the instruction needs the multi-cycle multiplier.
    function automatic logic is_mul(input logic [INSTR_W-1:0] instr);
        return (instr[OP_HI:OP_LO] == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_issue_queue_fifo.sv
// Circular instruction buffer feeding the issue FSM. A flush empties the buffer
// and discards any word pushed in the same cycle; a pop is also suppressed.
module instr_fifo
    import alu_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [INSTR_W-1:0]       wdata_i,
    output logic [INSTR_W-1:0]       rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               do_push_s;
    logic               do_pop_s;

    assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o   = (count_q == (PTR_W+1)'(0));
    assign do_push_s = push_i & ~full_o & ~flush_i;
    assign do_pop_s  = pop_i & ~empty_o & ~flush_i;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = (PTR_W+1)'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= (PTR_W+1)'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; cleared on reset so the head never presents X.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INSTR_W'(0);
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue queue in front of the 8-bit ALU: buffers instructions and presents one
// at a time, holding it for its op-dependent latency and flagging completion.
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ALU_CYCLES  = 1,
    parameter int MULT_CYCLES = 9,
    parameter int CNT_W       = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [INSTR_W-1:0]       alu_instr,
    output logic                     alu_check,
    output logic                     busy,
    output logic                     res_valid,
    output logic [1:0]               res_op,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    // Counter load values: the op stays in HOLD for (load + 1) cycles.
    localparam logic [CNT_W-1:0] ALU_LOAD = CNT_W'(ALU_CYCLES - 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);

    issue_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [INSTR_W-1:0] alu_instr_q, alu_instr_d;
    logic [INSTR_W-1:0] head_s;
    logic               alu_check_q, alu_check_d;
    logic               res_valid_q, res_valid_d;
    logic [1:0]         res_op_q, res_op_d;
    logic               busy_q, busy_d;
    logic               full_s, empty_s;
    logic               push_s, pop_s, can_pop_s;

    // in_ready depends only on the registered occupancy: no pop credit when full.
    assign in_ready  = ~full_s;
    assign push_s    = in_valid & ~full_s;
    assign can_pop_s = ~empty_s & ~flush;
    assign busy_d    = (state_d != ST_IDLE);

    instr_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (flush),
        .wdata_i (in_instr),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (fifo_count)
    );

    // Issue FSM: pop from IDLE or DONE, hold the word in HOLD, pulse result in DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_instr_d = alu_instr_q;
        alu_check_d = 1'b0;
        res_valid_d = 1'b0;
        res_op_d    = 2'b00;
        pop_s       = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (can_pop_s) begin
                    pop_s       = 1'b1;
                    alu_instr_d = head_s;
                    cnt_d       = is_mul(head_s) ? MUL_LOAD : ALU_LOAD;
                    alu_check_d = is_mul(head_s);
                    state_d     = ST_HOLD;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(0)) begin
                    state_d     = ST_DONE;
                    res_valid_d = 1'b1;
                    res_op_d    = instr_op(alu_instr_q);
                end else begin
                    cnt_d       = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs; reset aborts any op in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_W'(0);
            alu_instr_q <= INSTR_W'(0);
            alu_check_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_op_q    <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_instr_q <= alu_instr_d;
            alu_check_q <= alu_check_d;
            res_valid_q <= res_valid_d;
            res_op_q    <= res_op_d;
            busy_q      <= busy_d;
        end
    end

    assign alu_instr = alu_instr_q;
    assign alu_check = alu_check_q;
    assign res_valid = res_valid_q;
    assign res_op    = res_op_q;
    assign busy      = busy_q;

endmodule
